// File: rtl/systolic_ctrl_if.sv
// Command, status, feed-schedule and result-drain signals between the
// systolic array controller and its host, operand feeders and result mux.
interface systolic_ctrl_if #(
  parameter int N      = 4,
  parameter int K_BITS = 8
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic              start;
  logic [K_BITS-1:0] k_len;
  logic              busy;
  logic              done;
  logic              array_clr;
  logic [K_BITS:0]   feed_cnt;
  logic [N-1:0]      row_valid;
  logic [N-1:0]      col_valid;
  // Result port: a row transfers on every rising edge where res_valid and
  // res_ready are both high; res_valid never depends on res_ready and, once
  // raised, holds with res_row stable until that transfer happens.
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_row;
  logic [2:0]        state;

  modport master (
    output start, k_len, res_ready,
    input  busy, done, array_clr, feed_cnt, row_valid, col_valid,
    input  res_valid, res_row, state
  );

  modport slave (
    input  start, k_len, res_ready,
    output busy, done, array_clr, feed_cnt, row_valid, col_valid,
    output res_valid, res_row, state
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic MAC array: clears the PEs,
// drives the skewed west/north feed schedule, then drains result rows.
module systolic_ctrl #(
  parameter int N      = 4,
  parameter int K_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = K_BITS + 1;
  localparam int XW = K_BITS + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [K_BITS-1:0] k_reg;
  logic [K_BITS-1:0] k_nxt;
  logic [CW-1:0]     feed_cnt_r;
  logic [CW-1:0]     feed_nxt;
  logic [RW-1:0]     row_r;
  logic [RW-1:0]     row_nxt;
  logic [CW-1:0]     term;
  logic              feed_last;
  logic              last_row;
  logic              row_hs;
  logic [N-1:0]      lane_nxt;

  logic              busy_r;
  logic              done_r;
  logic              clr_r;
  logic [N-1:0]      row_valid_r;
  logic [N-1:0]      col_valid_r;
  logic              res_valid_r;

  // Last feed index K+2N-3; one extra bit keeps K = 2^K_BITS-1 from wrapping.
  assign term      = CW'(k_reg) + CW'(2 * N - 3);
  assign feed_last = (feed_cnt_r == term);
  assign last_row  = (row_r == RW'(N - 1));
  assign row_hs    = (state == DRAIN) && bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k_reg;
    feed_nxt  = feed_cnt_r;
    row_nxt   = row_r;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLEAR;
          k_nxt     = bus.k_len;
        end
      end
      CLEAR: begin
        feed_nxt = '0;
        if (k_reg != '0) begin
          state_nxt = FEED;
        end else begin
          state_nxt = DRAIN;
          row_nxt   = '0;
        end
      end
      FEED: begin
        if (feed_last) begin
          state_nxt = DRAIN;
          row_nxt   = '0;
        end else begin
          feed_nxt = feed_cnt_r + CW'(1);
        end
      end
      DRAIN: begin
        if (row_hs) begin
          if (last_row) begin
            state_nxt = DONE;
          end else begin
            row_nxt = row_r + RW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Lane i carries operand index t-i, so it is live for i <= t < i+K.
  always_comb begin
    lane_nxt = '0;
    for (int i = 0; i < N; i++) begin
      lane_nxt[i] = (state_nxt == FEED) &&
                    (XW'(feed_nxt) >= XW'(i)) &&
                    (XW'(feed_nxt) < (XW'(i) + XW'(k_nxt)));
    end
  end

  // Outputs are registered from next-state values so they switch cleanly
  // with the state register and never see res_ready or start combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg       <= '0;
      feed_cnt_r  <= '0;
      row_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      clr_r       <= 1'b0;
      row_valid_r <= '0;
      col_valid_r <= '0;
      res_valid_r <= 1'b0;
    end else begin
      k_reg       <= k_nxt;
      feed_cnt_r  <= feed_nxt;
      row_r       <= row_nxt;
      busy_r      <= (state_nxt != IDLE);
      done_r      <= (state_nxt == DONE);
      clr_r       <= (state_nxt == CLEAR);
      row_valid_r <= lane_nxt;
      col_valid_r <= lane_nxt;
      res_valid_r <= (state_nxt == DRAIN);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.array_clr = clr_r;
  assign bus.feed_cnt  = feed_cnt_r;
  assign bus.row_valid = row_valid_r;
  assign bus.col_valid = col_valid_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_row   = row_r;
  assign bus.state     = state;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: timeline reference model, behavioural PE array,
// directed vector table, reset/abort sequence and randomized runs.
module tb_systolic_ctrl;
  localparam int N    = 4;
  localparam int KB   = 8;
  localparam int RW   = $clog2(N);
  localparam int KMAX = 16;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr;
    logic [KB:0]   fc;
    logic [N-1:0]  rv;
    logic [N-1:0]  cv;
    logic          resv;
    logic [RW-1:0] row;
  } obs_t;

  typedef struct {
    int k;
    int stall_row;
    int stall_len;
    bit busy_pulse;
    bit ident;
    int exp_done;
    int exp_feed;
    int exp_fcmax;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  // Reference timeline of the current run, in cycles relative to its start.
  bit          m_active = 1'b0;
  int          m_start = 0;
  int          m_k = 0;
  int          m_rows = 0;
  int          m_done_cyc = -1;
  logic [KB:0] m_fc = '0;

  int a_m[N][KMAX];
  int b_m[KMAX][N];
  int c_m[N][N];
  int acc[N][N];
  int a_reg[N][N];
  int b_reg[N][N];
  bit arr_chk = 1'b0;

  systolic_ctrl_if #(.N(N), .K_BITS(KB)) bus ();
  systolic_ctrl #(.N(N), .K_BITS(KB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cycle, got, exp);
    end
  endtask

  function automatic obs_t got_obs();
    obs_t o;
    o.busy = bus.busy;
    o.done = bus.done;
    o.clr  = bus.array_clr;
    o.fc   = bus.feed_cnt;
    o.rv   = bus.row_valid;
    o.cv   = bus.col_valid;
    o.resv = bus.res_valid;
    o.row  = bus.res_row;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int rel, t, feed_end, drain_start;
    o = '0;
    o.fc = m_fc;
    if (m_active) begin
      rel = cycle - m_start;
      feed_end = m_k + 2 * N - 1;
      drain_start = (m_k == 0) ? 2 : m_k + 2 * N;
      o.busy = (rel >= 1);
      o.clr = (rel == 1);
      if (m_k != 0 && rel >= 2 && rel <= feed_end) begin
        t = rel - 2;
        o.fc = (KB + 1)'(t);
        for (int i = 0; i < N; i++) o.rv[i] = (t >= i) && (t < i + m_k);
        o.cv = o.rv;
      end
      if (rel >= drain_start && m_rows < N) begin
        o.resv = 1'b1;
        o.row = RW'(m_rows);
      end
      o.done = (cycle == m_done_cyc);
    end
    return o;
  endfunction

  // One clock cycle: drive inputs, compare, step model and behavioural array.
  task automatic tick(input logic s, input logic [KB-1:0] k, input logic rdy);
    obs_t e, g;
    int rel, idx;
    int ain[N][N];
    int bin[N][N];
    bus.start = s;
    bus.k_len = k;
    bus.res_ready = rdy;
    e = model_obs();
    g = got_obs();
    if (!e.resv) g.row = '0;
    check("outputs", 64'(g), 64'(e));
    if (arr_chk && bus.res_valid && rdy) begin
      for (int j = 0; j < N; j++)
        check("result_elem", 64'(acc[int'(bus.res_row)][j]), 64'(c_m[int'(bus.res_row)][j]));
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) begin
          idx = int'(bus.feed_cnt) - i;
          ain[i][j] = (bus.row_valid[i] && idx >= 0 && idx < KMAX) ? a_m[i][idx] : 0;
        end else begin
          ain[i][j] = a_reg[i][j-1];
        end
        if (i == 0) begin
          idx = int'(bus.feed_cnt) - j;
          bin[i][j] = (bus.col_valid[j] && idx >= 0 && idx < KMAX) ? b_m[idx][j] : 0;
        end else begin
          bin[i][j] = b_reg[i-1][j];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.array_clr) begin
          acc[i][j] = 0;
          a_reg[i][j] = 0;
          b_reg[i][j] = 0;
        end else begin
          acc[i][j] += ain[i][j] * bin[i][j];
          a_reg[i][j] = ain[i][j];
          b_reg[i][j] = bin[i][j];
        end
      end
    end
    rel = cycle - m_start;
    if (m_active) begin
      if (e.resv && rdy) begin
        m_rows++;
        if (m_rows == N) m_done_cyc = cycle + 1;
      end
      m_fc = (rel == 1) ? '0 : e.fc;
      if (cycle == m_done_cyc) m_active = 1'b0;
    end else begin
      m_fc = e.fc;
      if (s) begin
        m_active = 1'b1;
        m_start = cycle;
        m_k = int'(k);
        m_rows = 0;
        m_done_cyc = -1;
      end
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic run(input int k, input int stall_row, input int stall_len,
                     input bit busy_pulse, input bit ident, input bit rnd,
                     output int done_rel, output int feed_n, output int clr_n,
                     output int fc_max);
    int stalls, t0, first_resv, rel, kl;
    bit fin;
    logic s, rdy;
    logic [KB-1:0] kk;
    stalls = 0;
    fin = 1'b0;
    first_resv = -1;
    done_rel = -1;
    clr_n = 0;
    fc_max = 0;
    for (int i = 0; i < N; i++)
      for (int q = 0; q < KMAX; q++) begin
        a_m[i][q] = ident ? int'(i == q) : int'($urandom_range(0, 7));
        b_m[q][i] = ident ? int'(i == q) : int'($urandom_range(0, 7));
      end
    kl = (k < KMAX) ? k : KMAX;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_m[i][j] = 0;
        for (int q = 0; q < kl; q++) c_m[i][j] += a_m[i][q] * b_m[q][j];
      end
    arr_chk = (k <= KMAX);
    t0 = cycle;
    tick(1'b1, KB'(k), 1'b1);
    for (int n = 0; n < 1000 && !fin; n++) begin
      rel = cycle - t0;
      s = 1'b0;
      kk = KB'($urandom);
      rdy = 1'b1;
      if (bus.array_clr) clr_n++;
      if (bus.res_valid && first_resv < 0) first_resv = rel;
      if (bus.busy && !bus.array_clr && !bus.res_valid && !bus.done &&
          int'(bus.feed_cnt) > fc_max) fc_max = int'(bus.feed_cnt);
      if (bus.done) begin
        done_rel = rel;
        fin = 1'b1;
      end
      if (rnd) begin
        rdy = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 5) == 0);
      end
      if (bus.res_valid && int'(bus.res_row) == stall_row && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end
      if (busy_pulse && bus.busy && !bus.array_clr && bus.feed_cnt == 9'd3) begin
        s = 1'b1;
        kk = 8'd9;
      end
      tick(s, kk, rdy);
    end
    feed_n = (first_resv < 0) ? -1 : first_resv - 2;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL run_timeout k=%0d got=no_done exp=done_within_budget", k);
    end
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
  endtask

  initial begin
    vec_t vt[7];
    int dr, fn, cn, fm;
    // k, stall_row, stall_len, busy_pulse, ident, done, feed cycles, max feed_cnt
    vt[0] = '{4,   -1, 0, 1'b0, 1'b1, 16,  10,  9};
    vt[1] = '{4,    2, 3, 1'b0, 1'b0, 19,  10,  9};
    vt[2] = '{0,   -1, 0, 1'b0, 1'b0, 6,   0,   0};
    vt[3] = '{255, -1, 0, 1'b0, 1'b0, 267, 261, 260};
    vt[4] = '{4,   -1, 0, 1'b1, 1'b0, 16,  10,  9};
    vt[5] = '{1,   -1, 0, 1'b0, 1'b0, 13,  7,   6};
    vt[6] = '{6,    1, 2, 1'b0, 1'b0, 20,  12,  11};

    bus.start = 1'b0;
    bus.k_len = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(got_obs()), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run(vt[v].k, vt[v].stall_row, vt[v].stall_len, vt[v].busy_pulse,
          vt[v].ident, 1'b0, dr, fn, cn, fm);
      check("done_latency", 64'(dr), 64'(vt[v].exp_done));
      check("feed_cycles", 64'(fn), 64'(vt[v].exp_feed));
      check("clear_cycles", 64'(cn), 64'(1));
      check("feed_cnt_max", 64'(fm), 64'(vt[v].exp_fcmax));
    end

    // Abort mid-FEED with an asynchronous reset, then a clean K=2 run.
    tick(1'b1, 8'd6, 1'b1);
    repeat (4) tick(1'b0, '0, 1'b1);
    check("busy_before_abort", 64'(bus.busy), 64'(1));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 64'(got_obs()), 64'(0));
    m_active = 1'b0;
    m_fc = '0;
    @(posedge clk);
    #1 check("reset_held_outputs", 64'(got_obs()), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    cycle += 2;
    run(2, -1, 0, 1'b0, 1'b0, 1'b0, dr, fn, cn, fm);
    check("restart_done_latency", 64'(dr), 64'(14));
    check("restart_feed_cycles", 64'(fn), 64'(8));
    check("restart_clear_cycles", 64'(cn), 64'(1));

    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(0, 12)), -1, 0, 1'b0, 1'b0, 1'b1, dr, fn, cn, fm);
      check("rand_clear_cycles", 64'(cn), 64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
